// File: rtl/mpr_pkg.sv
// mpr_pkg: slot-state encoding and default geometry shared by the scheduler and its bench.
// Holds no logic, so it has no latency and no flow control of its own.
package mpr_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    PARKED = 2'd1,
    READY  = 2'd2
  } slot_state_e;

  localparam int MPR_NUM_SLOTS = 4;
  localparam int MPR_ADDR_W    = 9;

endpackage

// File: rtl/mpr_scheduler_rr_pick.sv
// rr_pick: first set request bit at or above start, wrapping round; purely combinational.
// Zero latency; no backpressure. N must be a power of two so the index wraps by truncation.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  // Walk from the far end back towards start so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[start + IW'(i)]) begin
        found = 1'b1;
        idx   = start + IW'(i);
      end
    end
  end

endmodule

// File: rtl/mpr_scheduler.sv
// mpr_scheduler: parks contexts, wakes them on address release, offers one registered restore at a time
// (free -> restore_valid in 2 edges, offer held until restore_ready). MPR_TIMEOUT_EN adds a per-slot watchdog.
module mpr_scheduler
  import mpr_pkg::*;
#(
  parameter int NUM_SLOTS = MPR_NUM_SLOTS,
  parameter int ADDR_W    = MPR_ADDR_W,
  parameter int TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         park_req,
  input  logic [ADDR_W-1:0]            park_addr,
  output logic                         park_ack,
  output logic [$clog2(NUM_SLOTS)-1:0] park_slot,
  output logic                         full,
  input  logic                         free_valid,
  input  logic [ADDR_W-1:0]            free_addr,
  output logic                         restore_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] restore_slot,
  input  logic                         restore_ready,
  output logic [NUM_SLOTS-1:0]         slot_busy,
  output logic                         timeout_pulse
);

  localparam int SW = $clog2(NUM_SLOTS);

  if (NUM_SLOTS < 2 || NUM_SLOTS > 8 || (NUM_SLOTS & (NUM_SLOTS - 1)) != 0) begin : g_bad_slots
    $error("mpr_scheduler: NUM_SLOTS must be a power of two in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mpr_scheduler: TIMEOUT must be at least 1");
  end

  slot_state_e          state_q [NUM_SLOTS];
  slot_state_e          state_d [NUM_SLOTS];
  logic [ADDR_W-1:0]    addr_q  [NUM_SLOTS];
  logic [ADDR_W-1:0]    addr_d  [NUM_SLOTS];
  logic [SW-1:0]        alloc_ptr_q, alloc_ptr_d;
  logic [SW-1:0]        rest_ptr_q, rest_ptr_d;
  logic [SW-1:0]        restore_slot_q, restore_slot_d;
  logic                 restore_valid_q, restore_valid_d;

  logic [NUM_SLOTS-1:0] empty_vec, ready_vec, expire;
  logic                 alloc_found, rest_found;
  logic [SW-1:0]        alloc_idx, rest_idx;

  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      empty_vec[s] = (state_q[s] == EMPTY);
      ready_vec[s] = (state_q[s] == READY);
    end
  end

  rr_pick #(.N(NUM_SLOTS)) u_alloc_pick (
    .req   (empty_vec),
    .start (alloc_ptr_q),
    .found (alloc_found),
    .idx   (alloc_idx)
  );

  rr_pick #(.N(NUM_SLOTS)) u_rest_pick (
    .req   (ready_vec),
    .start (rest_ptr_q),
    .found (rest_found),
    .idx   (rest_idx)
  );

  assign full          = ~alloc_found;
  assign park_ack      = park_req & ~full;
  assign park_slot     = alloc_idx;
  assign slot_busy     = ~empty_vec;
  assign restore_valid = restore_valid_q;
  assign restore_slot  = restore_slot_q;

`ifdef MPR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q [NUM_SLOTS];
  logic [CNT_W-1:0] cnt_d [NUM_SLOTS];
  logic             timeout_pulse_q, timeout_pulse_d;

  // Any non-PARKED slot holds zero, so the count restarts on every new park.
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      expire[s] = (state_q[s] == PARKED) && (cnt_q[s] == CNT_W'(TIMEOUT - 1));
      cnt_d[s]  = (state_q[s] == PARKED) ? cnt_q[s] + CNT_W'(1) : '0;
    end
    timeout_pulse_d = |expire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) cnt_q[s] <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) cnt_q[s] <= cnt_d[s];
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign timeout_pulse = timeout_pulse_q;
`else
  assign expire        = '0;
  assign timeout_pulse = 1'b0;
`endif

  // Park targets a pre-edge EMPTY slot, free/expiry only PARKED ones, restore only the granted READY one,
  // so the three updates never touch the same slot in one cycle.
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      state_d[s] = state_q[s];
      addr_d[s]  = addr_q[s];
    end
    alloc_ptr_d     = alloc_ptr_q;
    rest_ptr_d      = rest_ptr_q;
    restore_valid_d = restore_valid_q;
    restore_slot_d  = restore_slot_q;

    for (int s = 0; s < NUM_SLOTS; s++) begin
      if ((free_valid && state_q[s] == PARKED && addr_q[s] == free_addr) || expire[s]) begin
        state_d[s] = READY;
      end
    end

    if (park_ack) begin
      state_d[alloc_idx] = PARKED;
      addr_d[alloc_idx]  = park_addr;
      alloc_ptr_d        = alloc_idx + SW'(1);
    end

    if (restore_valid_q) begin
      if (restore_ready) begin
        state_d[restore_slot_q] = EMPTY;
        rest_ptr_d              = restore_slot_q + SW'(1);
        restore_valid_d         = 1'b0;
      end
    end else if (rest_found) begin
      restore_valid_d = 1'b1;
      restore_slot_d  = rest_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        state_q[s] <= EMPTY;
        addr_q[s]  <= '0;
      end
      alloc_ptr_q     <= '0;
      rest_ptr_q      <= '0;
      restore_valid_q <= 1'b0;
      restore_slot_q  <= '0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        state_q[s] <= state_d[s];
        addr_q[s]  <= addr_d[s];
      end
      alloc_ptr_q     <= alloc_ptr_d;
      rest_ptr_q      <= rest_ptr_d;
      restore_valid_q <= restore_valid_d;
      restore_slot_q  <= restore_slot_d;
    end
  end

endmodule

// File: tb/tb_mpr_scheduler.sv
// Bench for mpr_scheduler: directed scenarios then random traffic, each cycle compared with a slot-table model.
// Define MPR_TIMEOUT_EN for both bench and RTL to exercise the watchdog with TIMEOUT=8.
module tb_mpr_scheduler;

  localparam int NS    = 4;
  localparam int AW    = 9;
  localparam int TB_TO = 8;
  localparam int S_EMPTY = 0, S_PARKED = 1, S_READY = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          park_req = 1'b0;
  logic [AW-1:0] park_addr = '0;
  logic          park_ack;
  logic [1:0]    park_slot;
  logic          full;
  logic          free_valid = 1'b0;
  logic [AW-1:0] free_addr = '0;
  logic          restore_valid;
  logic [1:0]    restore_slot;
  logic          restore_ready = 1'b0;
  logic [NS-1:0] slot_busy;
  logic          timeout_pulse;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mpr_scheduler #(.NUM_SLOTS(NS), .ADDR_W(AW), .TIMEOUT(TB_TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .park_req      (park_req),
    .park_addr     (park_addr),
    .park_ack      (park_ack),
    .park_slot     (park_slot),
    .full          (full),
    .free_valid    (free_valid),
    .free_addr     (free_addr),
    .restore_valid (restore_valid),
    .restore_slot  (restore_slot),
    .restore_ready (restore_ready),
    .slot_busy     (slot_busy),
    .timeout_pulse (timeout_pulse)
  );

  // Reference: a table of slot states plus the two round-robin pointers and the outstanding offer.
  int ms [NS];
  int ma [NS];
  int mage [NS];
  int maptr, mrptr, mrs;
  bit mrv, mtp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find_from(input int start, input int want);
    for (int k = 0; k < NS; k++) begin
      if (ms[(start + k) % NS] == want) return (start + k) % NS;
    end
    return -1;
  endfunction

  function automatic logic [NS-1:0] m_busy();
    logic [NS-1:0] b;
    for (int s = 0; s < NS; s++) b[s] = (ms[s] != S_EMPTY);
    return b;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      ms[s] = S_EMPTY; ma[s] = 0; mage[s] = 0;
    end
    maptr = 0; mrptr = 0; mrs = 0; mrv = 1'b0; mtp = 1'b0;
  endtask

  task automatic model_edge();
    int nst [NS];
    int pslot, p;
    pslot = find_from(maptr, S_EMPTY);
    p     = find_from(mrptr, S_READY);
    nst   = ms;
    mtp   = 1'b0;
    for (int s = 0; s < NS; s++)
      if (free_valid && ms[s] == S_PARKED && ma[s] == int'(free_addr)) nst[s] = S_READY;
`ifdef MPR_TIMEOUT_EN
    for (int s = 0; s < NS; s++) begin
      if (ms[s] == S_PARKED) begin
        if (mage[s] == TB_TO - 1) begin
          nst[s] = S_READY;
          mtp    = 1'b1;
        end
        mage[s]++;
      end
    end
`endif
    if (park_req && pslot >= 0) begin
      nst[pslot]  = S_PARKED;
      ma[pslot]   = int'(park_addr);
      mage[pslot] = 0;
      maptr       = (pslot + 1) % NS;
    end
    if (mrv) begin
      if (restore_ready) begin
        nst[mrs] = S_EMPTY;
        mrptr    = (mrs + 1) % NS;
        mrv      = 1'b0;
      end
    end else if (p >= 0) begin
      mrv = 1'b1;
      mrs = p;
    end
    ms = nst;
  endtask

  // Inputs are set just after an edge; outputs are checked 1ns later, then the model takes the edge.
  task automatic step();
    bit mfull;
    #1;
    mfull = (find_from(maptr, S_EMPTY) < 0);
    chk("full", full, mfull);
    chk("park_ack", park_ack, park_req && !mfull);
    if (!mfull) chk("park_slot", park_slot, find_from(maptr, S_EMPTY));
    chk("slot_busy", slot_busy, m_busy());
    chk("restore_valid", restore_valid, mrv);
    if (mrv) chk("restore_slot", restore_slot, mrs);
    chk("timeout_pulse", timeout_pulse, mtp);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    park_req = 1'b0; free_valid = 1'b0; restore_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic park(input logic [AW-1:0] a, input int exp_slot);
    park_req = 1'b1; park_addr = a;
    #1;
    chk("dir_park_slot", park_slot, exp_slot);
    step();
    park_req = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Post-reset outputs.
    park_req = 1'b1;
    #1;
    chk("rst_park_ack", park_ack, 1);
    chk("rst_park_slot", park_slot, 0);
    chk("rst_full", full, 0);
    chk("rst_busy", slot_busy, 0);
    chk("rst_rv", restore_valid, 0);
    park_req = 1'b0;

    // Fill all four slots, then a fifth request is refused.
    for (int i = 0; i < NS; i++) park(AW'(9'h10 + i), i);
    park_req = 1'b1; park_addr = 9'h14;
    #1;
    chk("fill_full", full, 1);
    chk("fill_ack", park_ack, 0);
    step();
    park_req = 1'b0;

    // Free 0x11: slot 1 offered two edges later and held while not ready.
    free_valid = 1'b1; free_addr = 9'h11;
    step();
    free_valid = 1'b0;
    step();
    chk("free_rv", restore_valid, 1);
    chk("free_rs", restore_slot, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_rv", restore_valid, 1);
      chk("hold_rs", restore_slot, 1);
    end
    restore_ready = 1'b1;
    step();
    restore_ready = 1'b0;
    chk("hs_rv_drop", restore_valid, 0);
    chk("hs_busy", slot_busy, 4'b1101);

    // Two slots share an address: restored 0 then 2 with a gap.
    do_reset();
    park(9'h20, 0);
    park(9'h99, 1);
    park(9'h20, 2);
    free_valid = 1'b1; free_addr = 9'h20;
    step();
    free_valid = 1'b0;
    restore_ready = 1'b1;
    step();
    chk("dup_first_rv", restore_valid, 1);
    chk("dup_first_rs", restore_slot, 0);
    step();
    chk("dup_gap_rv", restore_valid, 0);
    step();
    chk("dup_second_rv", restore_valid, 1);
    chk("dup_second_rs", restore_slot, 2);
    step();
    restore_ready = 1'b0;
    chk("dup_done_busy", slot_busy, 4'b0010);

    // Park and free of the same address in one cycle: the new slot stays parked.
    park_req = 1'b1; park_addr = 9'h30;
    free_valid = 1'b1; free_addr = 9'h30;
    #1;
    chk("same_park_slot", park_slot, 3);
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("same_rv", restore_valid, 0);
    end
    chk("same_busy", slot_busy, 4'b1010);

    // Asynchronous reset while an offer is up.
    free_valid = 1'b1; free_addr = 9'h99;
    step();
    free_valid = 1'b0;
    step();
    chk("arst_pre_rv", restore_valid, 1);
    rst = 1'b1;
    #2;
    chk("arst_rv", restore_valid, 0);
    chk("arst_busy", slot_busy, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef MPR_TIMEOUT_EN
    park(9'h40, 0);
    for (int k = 1; k <= TB_TO; k++) begin
      step();
      chk("wdog_pulse", timeout_pulse, (k == TB_TO) ? 1 : 0);
    end
    step();
    chk("wdog_rv", restore_valid, 1);
    chk("wdog_rs", restore_slot, 0);
    chk("wdog_pulse_off", timeout_pulse, 0);
    do_reset();
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      park_req      = ($urandom_range(0, 99) < 50);
      park_addr     = AW'(9'h50 + $urandom_range(0, 3));
      free_valid    = ($urandom_range(0, 99) < 30);
      free_addr     = AW'(9'h50 + $urandom_range(0, 3));
      restore_ready = ($urandom_range(0, 99) < 60);
      step();
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mpr_scheduler.md
MPR_SCHEDULER -- requirements
Module: mpr_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, meaning the number of parked-context slots (power of two, 2..8).
REQ-002 SHALL have parameter ADDR_W, default 9, meaning the width of a conflict address.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the watchdog limit in cycles (used only with MPR_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port park_req  input  1  request to park the current context.
REQ-007 SHALL have port park_addr  input  ADDR_W  conflict address of the context being parked.
REQ-008 SHALL have port park_ack  output  1  park accepted this cycle.
REQ-009 SHALL have port park_slot  output  $clog2(NUM_SLOTS)  slot that receives the parked context.
REQ-010 SHALL have port full  output  1  no EMPTY slot.
REQ-011 SHALL have port free_valid  input  1  an address has been released.
REQ-012 SHALL have port free_addr  input  ADDR_W  released address.
REQ-013 SHALL have port restore_valid  output  1  a slot is offered for restore.
REQ-014 SHALL have port restore_slot  output  $clog2(NUM_SLOTS)  offered slot, which drives the slot mux select.
REQ-015 SHALL have port restore_ready  input  1  core accepts the offered restore.
REQ-016 SHALL have port slot_busy  output  NUM_SLOTS  per-slot bit: state is not EMPTY.
REQ-017 SHALL have port timeout_pulse  output  1  watchdog fired (tied 0 without MPR_TIMEOUT_EN).

Function
REQ-018 SHALL keep a per-slot state EMPTY, PARKED or READY, plus a stored ADDR_W address per slot.
REQ-019 SHALL drive park_ack combinationally as park_req && !full.
REQ-020 SHALL drive park_slot as the first EMPTY slot found scanning upward with wrap from alloc_ptr.
REQ-021 SHALL, on an accepted park at the clock edge, set that slot to PARKED, store park_addr, and set alloc_ptr to park_slot+1 mod NUM_SLOTS.
REQ-022 SHALL, on free_valid at an edge, set every PARKED slot whose stored address equals free_addr to READY; a non-matching free is ignored.
REQ-023 SHALL not match a slot parked in the same cycle as a free of the same address; free acts only on pre-edge PARKED slots.
REQ-024 SHALL register restore_valid and restore_slot; when no grant is held, the next edge loads the first READY slot scanning upward with wrap from rest_ptr.
REQ-025 SHALL hold restore_valid and restore_slot stable while restore_valid && !restore_ready.
REQ-026 SHALL treat restore_valid && restore_ready at an edge as a handshake: the slot becomes EMPTY, rest_ptr becomes slot+1 mod NUM_SLOTS, and restore_valid drops for at least one cycle.
REQ-027 SHALL not let a slot emptied by a restore at edge E be allocated by a park evaluated before E.
REQ-028 SHALL have a latency of two edges from free_valid to restore_valid: free sampled at E0, grant loaded at E1, restore_valid high after E1.
REQ-029 SHALL derive full and slot_busy combinationally from the state registers.

Reset
REQ-030 SHALL, on rst assertion (async, including mid-handshake), set all slots EMPTY, stored addresses 0, alloc_ptr 0, rest_ptr 0, restore_valid 0, restore_slot 0 and timeout_pulse 0, and drop any held grant.
REQ-031 SHALL hold outputs after reset as: park_ack = park_req, park_slot 0, full 0, slot_busy 0.

Configuration
REQ-032 SHALL, when MPR_TIMEOUT_EN is defined, give each slot a cycle counter that clears on PARKED entry and increments while PARKED; at TIMEOUT the slot is forced READY and timeout_pulse is high for one cycle.
REQ-033 SHALL, when MPR_TIMEOUT_EN is undefined, contain no counters, tie timeout_pulse to 0, and leave PARKED slots waiting indefinitely for a free.

Structure
REQ-034 SHALL define the slot-state enum (EMPTY, PARKED, READY) and the default ADDR_W and NUM_SLOTS constants in shared package mpr_pkg.
REQ-035 SHALL implement both scans with one sub-module rr_pick (NUM_SLOTS request vector plus start pointer in; found flag plus index out), instantiated twice.

Verification
REQ-036 SHALL cover: reset, then 4 parks with addresses 0x10..0x13 -> park_slot 0,1,2,3 and full=1; a 5th park_req -> park_ack=0.
REQ-037 SHALL cover: free 0x11 at E0 -> slot 1 READY, restore_valid=1 with restore_slot=1 after E1; restore_ready held 0 for 3 cycles -> outputs stable.
REQ-038 SHALL cover: slots 0 and 2 both parked with 0x20, then free 0x20 -> both READY, restored in order 0 then 2 with one idle cycle between.
REQ-039 SHALL cover: park 0x30 and free 0x30 in the same cycle -> new slot stays PARKED and restore_valid stays 0.
REQ-040 SHALL cover: rst asserted while restore_valid=1 -> restore_valid=0 and slot_busy=0 immediately, without waiting for a clock edge.
REQ-041 SHALL cover, with MPR_TIMEOUT_EN and TIMEOUT=8: park then no free -> timeout_pulse after 8 cycles and restore_valid on that slot.
